// File: rtl/edge_pkg.sv
// edge_pkg: shared state encoding and default hold widths for edge_to_level
package edge_pkg;
    typedef enum logic [1:0] {
        LOW       = 2'd0,
        HIGH_HOLD = 2'd1,
        HIGH      = 2'd2,
        LOW_HOLD  = 2'd3
    } state_t;
    localparam int DEF_MIN_HIGH = 4;
    localparam int DEF_MIN_LOW  = 4;
endpackage

// File: rtl/edge_to_level_if.sv
// edge_to_level_if: edge request pulses in, generated level and status out
interface edge_to_level_if #(
    parameter int ERRW = 8
) ();
    logic            rise;
    logic            down;
    logic            level;
    logic            busy;
    logic            pend;
    logic [ERRW-1:0] err_cnt;
    modport master (output rise, down, input level, busy, pend, err_cnt);
    modport slave  (input rise, down, output level, busy, pend, err_cnt);
endinterface

// File: rtl/hold_timer.sv
// hold_timer: loadable down-counter that parks at zero
module hold_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          zero
);
    logic [CW-1:0] cnt;
    assign zero = cnt == '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= load ? load_val : zero ? cnt : cnt - 1'b1;
    end
endmodule

// File: rtl/edge_to_level.sv
// edge_to_level: turns rise/down event pulses into a level with minimum high/low widths,
// pending one early request and counting rejected ones
module edge_to_level
    import edge_pkg::*;
#(
    parameter int MIN_HIGH = DEF_MIN_HIGH,
    parameter int MIN_LOW  = DEF_MIN_LOW,
    parameter int CW       = 8,
    parameter int ERRW     = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    edge_to_level_if.slave bus
);
    state_t        state, nxt;
    logic          r, d, zero, go_hh, go_lh, err, nxt_pend, load;
    logic [CW-1:0] load_val;
    always_comb begin
        r        = bus.rise & ~bus.down;
        d        = bus.down & ~bus.rise;
        go_hh    = 1'b0;
        go_lh    = 1'b0;
        err      = 1'b0;
        nxt_pend = bus.pend;
        // a same-direction request on the expiry cycle is taken at once rather than pended
        case (state)
            LOW: begin
                go_hh = r;
                err   = bus.down;
            end
            HIGH_HOLD: begin
                go_lh    = zero & (bus.pend | d);
                err      = bus.rise | (d & bus.pend);
                nxt_pend = ~zero & (bus.pend | d);
            end
            HIGH: begin
                go_lh = d;
                err   = bus.rise;
            end
            LOW_HOLD: begin
                go_hh    = zero & (bus.pend | r);
                err      = bus.down | (r & bus.pend);
                nxt_pend = ~zero & (bus.pend | r);
            end
            default: ;
        endcase
        nxt = go_hh ? HIGH_HOLD : go_lh ? LOW_HOLD : !zero ? state :
              state == HIGH_HOLD ? HIGH : state == LOW_HOLD ? LOW : state;
        load     = go_hh | go_lh;
        load_val = go_hh ? CW'(MIN_HIGH - 1) : CW'(MIN_LOW - 1);
    end
    hold_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .zero     (zero)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOW;
            bus.level   <= 1'b0;
            bus.busy    <= 1'b0;
            bus.pend    <= 1'b0;
            bus.err_cnt <= '0;
        end else begin
            state     <= nxt;
            bus.level <= nxt[0] ^ nxt[1];
            bus.busy  <= nxt[0];
            bus.pend  <= nxt_pend;
            if (err && bus.err_cnt != {ERRW{1'b1}})
                bus.err_cnt <= bus.err_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_edge_to_level.sv
// tb_edge_to_level: directed vector table plus corner sequences and a random width scoreboard
module tb_edge_to_level;
    localparam int MIN_H = 4;
    localparam int MIN_L = 4;
    typedef struct {
        logic r, d, lvl, bsy, pnd;
        int   err;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    vec_t vq[$];
    edge_to_level_if #(.ERRW(8)) bus ();
    edge_to_level #(.MIN_HIGH(MIN_H), .MIN_LOW(MIN_L), .CW(8), .ERRW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic tick(input logic r, input logic d);
        bus.rise = r;
        bus.down = d;
        @(posedge clk);
        #1;
        bus.rise = 1'b0;
        bus.down = 1'b0;
    endtask
    task automatic do_reset();
        @(negedge clk);
        bus.rise = 1'b0;
        bus.down = 1'b0;
        rst_n = 1'b0;
        #20;
        rst_n = 1'b1;
    endtask
    task automatic add(input logic r, d, l, b, p, input int e);
        vq.push_back('{r, d, l, b, p, e});
    endtask
    task automatic chk_out(input string tag, input int l, b, p, e);
        chk({tag, ".level"}, int'(bus.level), l);
        chk({tag, ".busy"}, int'(bus.busy), b);
        chk({tag, ".pend"}, int'(bus.pend), p);
        chk({tag, ".err_cnt"}, int'(bus.err_cnt), e);
    endtask
    initial begin
        int falls, run, prev, first;
        bus.rise = 1'b0;
        bus.down = 1'b0;
        add(0,0, 0,0,0,0); add(1,0, 1,1,0,0); add(0,1, 1,1,1,0); add(0,0, 1,1,1,0);
        add(0,0, 1,1,1,0); add(0,0, 0,1,0,0); add(1,0, 0,1,1,0); add(0,1, 0,1,1,1);
        add(0,0, 0,1,1,1); add(0,0, 1,1,0,1); add(1,0, 1,1,0,2); add(0,0, 1,1,0,2);
        add(0,0, 1,1,0,2); add(0,0, 1,0,0,2); add(1,0, 1,0,0,3); add(1,1, 1,0,0,4);
        add(0,1, 0,1,0,4); add(0,0, 0,1,0,4); add(0,0, 0,1,0,4); add(0,0, 0,1,0,4);
        add(0,0, 0,0,0,4); add(1,1, 0,0,0,5); add(0,1, 0,0,0,6); add(1,0, 1,1,0,6);
        add(0,0, 1,1,0,6); add(0,0, 1,1,0,6); add(0,0, 1,1,0,6); add(0,1, 0,1,0,6);
        add(0,0, 0,1,0,6); add(0,0, 0,1,0,6); add(0,0, 0,1,0,6); add(1,0, 1,1,0,6);
        do_reset();
        chk_out("reset", 0, 0, 0, 0);
        foreach (vq[i]) begin
            tick(vq[i].r, vq[i].d);
            chk_out($sformatf("vec%0d", i), vq[i].lvl, vq[i].bsy, vq[i].pnd, vq[i].err);
        end
        // double down while high-hold: one pend, one error, a single fall
        do_reset();
        tick(1, 1);
        chk_out("both_low", 0, 0, 0, 1);
        tick(1, 0);
        tick(0, 1);
        tick(0, 1);
        chk_out("dbl_down", 1, 1, 1, 2);
        falls = 0;
        prev = 1;
        for (int i = 0; i < 12; i++) begin
            tick(0, 0);
            if (prev == 1 && bus.level == 1'b0) falls++;
            prev = int'(bus.level);
        end
        chk("dbl_down.falls", falls, 1);
        chk_out("dbl_down.end", 0, 0, 0, 2);
        // saturation
        do_reset();
        for (int i = 1; i <= 300; i++) begin
            tick(0, 1);
            if (i == 254) chk("sat.254", int'(bus.err_cnt), 254);
            if (i == 255) chk("sat.255", int'(bus.err_cnt), 255);
        end
        chk_out("sat.300", 0, 0, 0, 255);
        // async reset between edges with pend set
        do_reset();
        tick(1, 1);
        tick(1, 0);
        tick(0, 1);
        chk_out("pre_async", 1, 1, 1, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_out("async", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        // random stimulus, every completed run must meet its minimum width
        run = 0;
        prev = 0;
        first = 1;
        for (int i = 0; i < 500; i++) begin
            tick(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
            if (int'(bus.level) == prev) run++;
            else begin
                if (!first) chk(prev ? "rand.high_run" : "rand.low_run", (run >= (prev ? MIN_H : MIN_L)) ? 1 : 0, 1);
                first = 0;
                prev = int'(bus.level);
                run = 1;
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/edge_to_level.md
# edge_to_level

Level generator that turns one-cycle `rise`/`down` event pulses back into a clean single-bit level, enforcing minimum high and low widths. It sits on the transmit side of any edge-event link: upstream logic issues edge commands, and `level` drives a pin or a downstream edge detector. Requests that arrive while the current level is still inside its minimum width are pended one deep. Illegal or redundant requests are counted.

## Interface
- `MIN_HIGH`, default 4: minimum cycles `level` stays 1 after rising; legal range 1..2^CW-1.
- `MIN_LOW`, default 4: minimum cycles `level` stays 0 after falling; legal range 1..2^CW-1.
- `CW`, default 8: hold counter width.
- `ERRW`, default 8: error counter width.
- `clk` input 1: clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `rise` input 1: request `level` 0→1, one-cycle pulse, synchronous to `clk`.
- `down` input 1: request `level` 1→0, one-cycle pulse, synchronous to `clk`.
- `level` output 1: generated level, registered.
- `busy` output 1: 1 while in a hold state (LOW_HOLD or HIGH_HOLD).
- `pend` output 1: a request is queued, to be applied when the hold expires.
- `err_cnt` output ERRW: saturating count of rejected requests.

## Operation
- States: LOW, HIGH_HOLD, HIGH, LOW_HOLD. `level` is 1 in HIGH_HOLD and HIGH, and 0 in LOW and LOW_HOLD.
- Reset (async, any time, including mid-hold with `pend` set) gives: state LOW, `level`=0, `busy`=0, `pend`=0, `err_cnt`=0, counter=0.
- `rise` and `down` sampled high in the same cycle, in any state: the cycle counts as one error and both are ignored.
- In LOW:
  - `rise` → HIGH_HOLD, counter ← MIN_HIGH-1.
  - `down` → error; stay in LOW.
- In HIGH:
  - `down` → LOW_HOLD, counter ← MIN_LOW-1.
  - `rise` → error; stay in HIGH.
- Hold behaviour (HIGH_HOLD; LOW_HOLD is symmetric with `rise`, `down` and MIN_LOW swapped):
  - Counter≠0: decrement.
  - `down` with `pend`=0: set `pend`.
  - `down` with `pend`=1: error; `pend` stays 1.
  - `rise`: error.
  - Counter=0 at the edge, `pend`=0: go to HIGH.
  - Counter=0 at the edge, `pend`=1: go directly to LOW_HOLD, counter ← MIN_LOW-1, clear `pend`.
  - A `down` arriving on the expiry cycle itself, with `pend`=0, is treated as if it had arrived in HIGH, i.e. it is taken immediately.
- `err_cnt` increments by 1 per error cycle and saturates at 2^ERRW-1. It never wraps.

## Timing
- Latency: `rise` sampled at edge n in LOW gives `level`=1 from edge n onward. The output is registered and there is no extra delay cycle.
- A hold state occupies exactly MIN_x cycles. With MIN_HIGH=1, HIGH_HOLD lasts one cycle.
- Pended request: `level` changes at the edge where the counter is 0, so the preceding level width equals exactly MIN_x cycles.
- `busy` and `pend` are registered and update on the same edge as the state.
- `err_cnt` updates on the edge after the offending sample becomes visible, i.e. the edge that samples it.
- Request inputs are never back-pressured. `busy` is advisory only.

## Structure
- Shared package `edge_pkg`:
  - state enum with 2-bit encoding: LOW=0, HIGH_HOLD=1, HIGH=2, LOW_HOLD=3;
  - default MIN_HIGH/MIN_LOW constants.
- Sub-module `hold_timer`, CW-bit down-counter:
  - inputs `load`, `load_val`;
  - output `zero`.
- The FSM, pend flag and error counter stay in the top level.

## Test plan
- Reset: hold `rst_n`=0 for 20 ns, then release → `level`=0, `busy`=0, `pend`=0, `err_cnt`=0. No output changes until the first request.
- Basic pulse, MIN_HIGH=4: one `rise` in LOW → `level`=1 from that edge, `busy`=1 for 4 cycles. Then `down` → `level`=0, `busy`=1 for 4 cycles, then state LOW.
- Pend: `rise`, then `down` one cycle later → `pend`=1. `level` falls exactly 4 cycles after it rose, `pend` clears on that edge, and LOW_HOLD follows.
- Errors: `rise` and `down` together in LOW → `level` stays 0, `err_cnt`=1. Two `down` pulses during HIGH_HOLD → `err_cnt`=2, with a single fall only.
- Saturation, ERRW=8: 300 redundant `down` pulses in LOW → `err_cnt`=255 and held there.
- Async reset: assert `rst_n` mid-HIGH_HOLD with `pend`=1, between clock edges → `level`, `busy`, `pend` and `err_cnt` clear immediately, with no clock needed.
- Random: `$random` `rise`/`down` stimulus for 500 cycles, with a scoreboard model checking every high and low run of `level` ≥ MIN_x.
